flt2int_iter: RTL and testbench
===============================

// Module: flt2int_iter
// PURPOSE
//  Iterative float-to-integer converter: FCVT.W.S (signed) / FCVT.WU.S (unsigned), RV32F semantics.
//  Inverse of the single-cycle integer-to-float path; sits beside it in the FPU on the EX stage.
//  Multi-cycle (shifts SHIFT_STEP bits/cycle); busy stalls the pipeline, valid pulses with the result.
// PARAMETERS
//  SHIFT_STEP  4  bits shifted per cycle in SHIFT state (legal 1..8)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   reset, asynchronous, active-low (0 = reset)
//  start      in   1   launch conversion of opa; sampled only when busy=0
//  opa        in   32  IEEE-754 single operand
//  is_signed  in   1   1 = FCVT.W.S, 0 = FCVT.WU.S
//  flt_rm     in   3   rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others = RNE
//  res        out  32  integer result, held from valid until next accepted start
//  valid      out  1   one-cycle pulse: res/flags valid
//  busy       out  1   high whenever state != IDLE
//  flag_nv    out  1   invalid, valid with res
//  flag_nx    out  1   inexact, valid with res
// BEHAVIOUR
//  Reset: state IDLE; res=0, valid=0, busy=0, flag_nv=0, flag_nx=0. Reset mid-conversion aborts, no valid.
//  Decode at start (cycle T): s=opa[31], e=opa[30:23], E=e-127, m={1,opa[22:0]}; opa/is_signed/flt_rm latched.
//  Datapath: 64-bit SR, int = SR[63:32], fraction = SR[31:0]; load SR = m<<32 (value = m).
//  FSM IDLE -> SHIFT | ROUND | DONE; SHIFT -> ROUND; ROUND -> DONE; DONE -> IDLE.
//   - NaN (e=255, frac!=0): DONE at T+1. res = 7FFFFFFF (signed) / FFFFFFFF (unsigned); NV=1.
//   - Inf or E>=32: DONE at T+1. Saturated: +: 7FFFFFFF / FFFFFFFF; -: 80000000 / 00000000; NV=1.
//   - e=0 (zero/denormal): zero -> DONE at T+1, res=0, NX=0. Denormal -> ROUND with int=0, guard=0, sticky=1.
//   - 0 < e, E<0: ROUND at T+1 with int=0; E=-1 -> guard=1, sticky=(frac!=0); E<-1 -> guard=0, sticky=1.
//   - 0<=E<=31: shift amount n=|E-23|, right if E<23, left if E>23.
//     SHIFT lasts k=ceil(n/SHIFT_STEP) cycles (each min(rem,SHIFT_STEP) bits); k=0 goes straight to ROUND.
//  Right shift max 23: no bits fall off the 32-bit fraction field, no sticky loss.
//  ROUND: guard=SR[31], sticky=|SR[30:0]; mag33 = int + inc, 33 bits wide.
//   inc per rm: RNE g&(st|int[0]); RTZ 0; RDN s&(g|st); RUP ~s&(g|st); RMM g.
//   NX = g|st. Overflow checked on mag33 after rounding:
//   - signed: s=0 & mag33>7FFFFFFF, or s=1 & mag33>80000000 -> saturate as above, NV=1, NX=0.
//   - unsigned: s=1 & mag33!=0, or mag33>FFFFFFFF -> saturate, NV=1, NX=0.
//   - otherwise res = s ? -mag33[31:0] : mag33[31:0].
//  DONE: valid=1, busy=1 for exactly one cycle; normal latency valid at T+k+2.
//  start while busy=1 is ignored; start in the cycle after DONE (IDLE) is accepted.
//  res/flags registered, change only on entry to DONE.
// TESTING
//  1 0x3FC00000 (1.5), signed: RNE -> 2, NX; RTZ -> 1, NX; RDN -> 1.
//    0x40200000 (2.5), RNE -> 2; RMM -> 3.
//  2 0xBFC00000 (-1.5), signed, RDN -> FFFFFFFE, NX.
//    0xBF000000 (-0.5), unsigned RTZ -> 0, NX=1, NV=0.
//    0xBF800000 (-1.0), unsigned -> 0, NV=1.
//  3 0x4F000000 (2^31): signed -> 7FFFFFFF, NV; unsigned -> 80000000, no flags.
//    0xCF000000, signed -> 80000000, no flags.
//    0x7FC00000 NaN, signed -> 7FFFFFFF, NV.
//  4 Latency, SHIFT_STEP=4: 0x3F800000 (1.0) start at T -> valid at T+8, res=1.
//    0x00000000 -> valid at T+1, res=0.
//    0x4B000000 (2^23, k=0) -> valid at T+2.
//  5 start pulsed every cycle during busy: exactly one result per accepted start; res stable between valids.
//  6 rst low mid-SHIFT: busy/valid/res/flags 0 immediately.
//    New start after reset release converts correctly.

Source files
------------

// File: rtl/flt2int_iter.sv
// Iterative float-to-integer converter (FCVT.W.S / FCVT.WU.S, RV32F).
// A 64-bit shift register holds the magnitude as int.fraction (SR[63:32] is
// the integer part). It is walked SHIFT_STEP bits per cycle and then rounded.
// busy covers the whole conversion; valid pulses for one cycle with the result.
module flt2int_iter #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic        is_signed,
  input  logic [2:0]  flt_rm,
  output logic [31:0] res,
  output logic        valid,
  output logic        busy,
  output logic        flag_nv,
  output logic        flag_nx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      r_state;
  logic [63:0] r_sr;
  logic [4:0]  r_rem;
  logic        r_left;
  logic        r_sgn;
  logic        r_signed;
  logic [2:0]  r_rm;
  logic [31:0] r_res;
  logic        r_valid;
  logic        r_busy;
  logic        r_nv;
  logic        r_nx;

  // Operand classification, evaluated on the raw input in the start cycle.
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic        w_is_nan;
  logic        w_is_sat;
  logic        w_is_zero;
  logic        w_is_small;
  logic        w_small_g;
  logic        w_small_st;
  logic [4:0]  w_shamt;

  assign w_exp      = opa[30:23];
  assign w_frac     = opa[22:0];
  assign w_is_nan   = (w_exp == 8'hFF) && (w_frac != '0);
  // Biased exponent 159 is E=32. This also covers infinity (e=255, frac=0).
  assign w_is_sat   = (w_exp >= 8'd159);
  assign w_is_zero  = (w_exp == 8'd0) && (w_frac == '0);
  // |value| < 1, denormals included: the integer part is already zero.
  assign w_is_small = (w_exp < 8'd127);
  assign w_small_g  = (w_exp == 8'd126);
  assign w_small_st = w_small_g ? (w_frac != '0) : 1'b1;
  // Biased exponent 150 is E=23, where the mantissa already sits in place.
  assign w_shamt    = (w_exp >= 8'd150) ? 5'(w_exp - 8'd150) : 5'(8'd150 - w_exp);

  // One shift step: the remaining distance, capped at SHIFT_STEP.
  logic [4:0]  w_step;
  logic [63:0] w_sr_shifted;

  assign w_step       = (r_rem > STEP) ? STEP : r_rem;
  assign w_sr_shifted = r_left ? (r_sr << w_step) : (r_sr >> w_step);

  // Rounding and range check on the aligned magnitude.
  logic [31:0] w_int;
  logic        w_g;
  logic        w_st;
  logic        w_inc;
  logic [32:0] w_mag;
  logic        w_ovf;
  logic [31:0] w_rnd_res;

  assign w_int = r_sr[63:32];
  assign w_g   = r_sr[31];
  assign w_st  = |r_sr[30:0];

  // Select the round-up increment for the latched rounding mode.
  always_comb begin
    // NOTE: default assignment first so that no path leaves w_inc unassigned (no latch).
    w_inc = w_g & (w_st | w_int[0]);
    case (r_rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sgn & (w_g | w_st);
      3'b011:  w_inc = ~r_sgn & (w_g | w_st);
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_st | w_int[0]);
    endcase
  end

  assign w_mag = {1'b0, w_int} + {32'b0, w_inc};
  assign w_ovf = r_signed ? (r_sgn ? (w_mag > 33'h080000000) : (w_mag > 33'h07FFFFFFF))
                          : ((r_sgn && (w_mag != '0)) || w_mag[32]);
  assign w_rnd_res = r_sgn ? (32'd0 - w_mag[31:0]) : w_mag[31:0];

  function automatic logic [31:0] sat_val(input logic neg, input logic sgnd);
    if (sgnd) return neg ? 32'h80000000 : 32'h7FFFFFFF;
    return neg ? 32'h00000000 : 32'hFFFFFFFF;
  endfunction

  // Conversion FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only; the combinational logic above uses blocking ones.
      r_state  <= ST_IDLE;
      r_sr     <= '0;
      r_rem    <= '0;
      r_left   <= 1'b0;
      r_sgn    <= 1'b0;
      r_signed <= 1'b0;
      r_rm     <= '0;
      r_res    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_nv     <= 1'b0;
      r_nx     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sgn    <= opa[31];
            r_signed <= is_signed;
            r_rm     <= flt_rm;
            r_busy   <= 1'b1;
            if (w_is_nan || w_is_sat) begin
              // A NaN saturates as positive, whatever its sign bit.
              r_res   <= sat_val(opa[31] & ~w_is_nan, is_signed);
              r_nv    <= 1'b1;
              r_nx    <= 1'b0;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else if (w_is_zero) begin
              r_res   <= '0;
              r_nv    <= 1'b0;
              r_nx    <= 1'b0;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else if (w_is_small) begin
              r_sr    <= {32'b0, w_small_g, w_small_st, 30'b0};
              r_state <= ST_ROUND;
            end else begin
              r_sr    <= {8'b0, 1'b1, w_frac, 32'b0};
              r_rem   <= w_shamt;
              r_left  <= (w_exp > 8'd150);
              r_state <= (w_shamt == '0) ? ST_ROUND : ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_sr  <= w_sr_shifted;
          r_rem <= r_rem - w_step;
          if (r_rem <= STEP) r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (w_ovf) begin
            r_res <= sat_val(r_sgn, r_signed);
            r_nv  <= 1'b1;
            r_nx  <= 1'b0;
          end else begin
            r_res <= w_rnd_res;
            r_nv  <= 1'b0;
            r_nx  <= w_g | w_st;
          end
          r_valid <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign res     = r_res;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign flag_nv = r_nv;
  assign flag_nx = r_nx;

endmodule

// File: tb/tb_flt2int_iter.sv
// Bench for flt2int_iter: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for start-while-busy and mid-conversion reset.
module tb_flt2int_iter;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] opa = '0;
  logic        is_signed = 1'b0;
  logic [2:0]  flt_rm = '0;
  logic [31:0] res;
  logic        valid;
  logic        busy;
  logic        flag_nv;
  logic        flag_nx;

  flt2int_iter #(.SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opa       (opa),
    .is_signed (is_signed),
    .flt_rm    (flt_rm),
    .res       (res),
    .valid     (valid),
    .busy      (busy),
    .flag_nv   (flag_nv),
    .flag_nx   (flag_nx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] opa;
    logic        sgn;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        nv;
    logic        nx;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        nv;
    logic        nx;
    int          start_cyc;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Spec latency T+L for a start sampled in cycle T, with SHIFT_STEP=STEP.
  function automatic int exp_lat(input logic [31:0] a);
    int e;
    int n;
    e = int'(a[30:23]);
    if (e == 255 || e >= 159 || (e == 0 && a[22:0] == 23'd0)) return 1;
    if (e < 127) return 2;
    n = (e >= 150) ? e - 150 : 150 - e;
    return 2 + (n + STEP - 1) / STEP;
  endfunction

  // Scoreboard: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res", res, e.res);
        check("flag_nv", {31'd0, flag_nv}, {31'd0, e.nv});
        check("flag_nx", {31'd0, flag_nx}, {31'd0, e.nx});
        check("latency", 32'(cyc - e.start_cyc), 32'(e.lat - 1));
        check("busy_with_valid", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Entered #1 after a posedge with the DUT idle; returns likewise.
  task automatic do_conv(input vec_t v);
    opa       = v.opa;
    is_signed = v.sgn;
    flt_rm    = v.rm;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{v.res, v.nv, v.nx, cyc, exp_lat(v.opa)});
    wait_drain(40);
    @(posedge clk); #1;
  endtask

  initial begin
    // {opa, is_signed, rm, expected res, nv, nx}
    vecs.push_back('{32'h3FC00000, 1'b1, 3'd0, 32'h00000002, 1'b0, 1'b1});
    vecs.push_back('{32'h3FC00000, 1'b1, 3'd1, 32'h00000001, 1'b0, 1'b1});
    vecs.push_back('{32'h3FC00000, 1'b1, 3'd2, 32'h00000001, 1'b0, 1'b1});
    vecs.push_back('{32'h3FC00000, 1'b1, 3'd3, 32'h00000002, 1'b0, 1'b1});
    vecs.push_back('{32'h40200000, 1'b1, 3'd0, 32'h00000002, 1'b0, 1'b1});
    vecs.push_back('{32'h40200000, 1'b1, 3'd4, 32'h00000003, 1'b0, 1'b1});
    vecs.push_back('{32'h40200000, 1'b1, 3'd5, 32'h00000002, 1'b0, 1'b1});
    vecs.push_back('{32'hBFC00000, 1'b1, 3'd2, 32'hFFFFFFFE, 1'b0, 1'b1});
    vecs.push_back('{32'hBFC00000, 1'b1, 3'd3, 32'hFFFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{32'hC0200000, 1'b1, 3'd0, 32'hFFFFFFFE, 1'b0, 1'b1});
    vecs.push_back('{32'hBF000000, 1'b0, 3'd1, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{32'hBF000000, 1'b0, 3'd2, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'hBF800000, 1'b0, 3'd0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h3FC00000, 1'b0, 3'd0, 32'h00000002, 1'b0, 1'b1});
    vecs.push_back('{32'h4F000000, 1'b1, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h4F000000, 1'b0, 3'd0, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{32'hCF000000, 1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{32'h4F7FFFFF, 1'b0, 3'd0, 32'hFFFFFF00, 1'b0, 1'b0});
    vecs.push_back('{32'h4F800000, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h4EFFFFFF, 1'b1, 3'd0, 32'h7FFFFF80, 1'b0, 1'b0});
    vecs.push_back('{32'h7FC00000, 1'b1, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h7FC00000, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h7F800000, 1'b0, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hFF800000, 1'b1, 3'd0, 32'h80000000, 1'b1, 1'b0});
    vecs.push_back('{32'hFF800000, 1'b0, 3'd0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h3F800000, 1'b1, 3'd0, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{32'h4B000000, 1'b1, 3'd0, 32'h00800000, 1'b0, 1'b0});
    vecs.push_back('{32'h4640E400, 1'b1, 3'd0, 32'h00003039, 1'b0, 1'b0});
    vecs.push_back('{32'h00000001, 1'b1, 3'd3, 32'h00000001, 1'b0, 1'b1});
    vecs.push_back('{32'h00000001, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{32'h80000001, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{32'h3F000000, 1'b1, 3'd0, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{32'h3F000000, 1'b1, 3'd4, 32'h00000001, 1'b0, 1'b1});
    vecs.push_back('{32'h3F400000, 1'b1, 3'd0, 32'h00000001, 1'b0, 1'b1});

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_res", res, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_nv", {31'd0, flag_nv}, 32'd0);
    check("rst_nx", {31'd0, flag_nx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_conv(vecs[i]);

    // start held high through busy: accepted only at cycles 0, 9 and 18.
    is_signed = 1'b1;
    flt_rm    = 3'd0;
    start     = 1'b1;
    for (int idx = 0; idx < 19; idx++) begin
      opa = (idx == 0) ? 32'h3F800000 : (idx == 9) ? 32'h40400000 :
            (idx == 18) ? 32'h40A00000 : 32'h7FC00000;
      @(posedge clk); #1;
      if (idx == 0)  sb.push_back('{32'd1, 1'b0, 1'b0, cyc, 8});
      if (idx == 9)  sb.push_back('{32'd3, 1'b0, 1'b0, cyc, 8});
      if (idx == 18) sb.push_back('{32'd5, 1'b0, 1'b0, cyc, 8});
      if (idx == 8)  check("idle_gap_busy", {31'd0, busy}, 32'd0);
      if (idx == 12) check("res_held", res, 32'd1);
    end
    start = 1'b0;
    opa   = '0;
    wait_drain(40);
    @(posedge clk); #1;
    check("res_held_after", res, 32'd5);

    // Reset asserted mid-SHIFT aborts the conversion.
    opa   = 32'h3F800000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_res", res, 32'd0);
    check("abort_nv", {31'd0, flag_nv}, 32'd0);
    check("abort_nx", {31'd0, flag_nx}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_conv('{32'h40400000, 1'b1, 3'd0, 32'h00000003, 1'b0, 1'b0});

    repeat (12) @(posedge clk);
    #1;
    check("final_idle", {31'd0, busy}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
